// File: rtl/register_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : register_arbiter_if
// Description : Request/commit bundle shared by the register arbiter and its
//               requesters. Carries the synchronous clear, the per-requester
//               valid/data/ready handshake and the committed-value outputs.
//               master : requester side (drives clr, req_valid, req_data)
//               slave  : arbiter side (drives req_ready, data_out, owner_id,
//                        wr_strobe, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface register_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                            clr;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]              req_ready;
    logic [DATA_WIDTH-1:0]           data_out;
    logic [c_ID_W-1:0]               owner_id;
    logic                            wr_strobe;
    logic                            busy;

    modport master (
        output clr, req_valid, req_data,
        input  req_ready, data_out, owner_id, wr_strobe, busy
    );

    modport slave (
        input  clr, req_valid, req_data,
        output req_ready, data_out, owner_id, wr_strobe, busy
    );
endinterface
`default_nettype wire

// File: rtl/register_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_arbiter
// Description : Round-robin arbiter in front of a single shared register.
//               One write is granted per cycle in IDLE; after each commit the
//               arbiter can sit in a quiet GAP for MIN_GAP cycles.
//               clk : rising-edge clock
//               rst : asynchronous active-high reset
//               bus : register_arbiter_if slave modport (clear, handshake,
//                     committed value, owner id, commit strobe, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module register_arbiter #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    NUM_REQ     = 4,
    parameter int                    MIN_GAP     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    register_arbiter_if.slave bus
);
    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(MIN_GAP);
    localparam logic [c_ID_W-1:0]  c_LAST_ID  = c_ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_ID_W-1:0]     r_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [c_ID_W-1:0]     r_owner;
    logic                  r_strobe;

    logic [DATA_WIDTH-1:0] w_req_word [NUM_REQ];
    logic [c_ID_W-1:0]     w_idx;
    logic [c_ID_W-1:0]     w_win;
    logic                  w_found;
    logic                  w_grant_ok;
    logic                  w_fire;
    logic [NUM_REQ-1:0]    w_ready;

    // Unpack the flat data bus so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_word[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating-priority scan: first valid requester at or above the pointer,
    // wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Clear and reset both suppress any grant in the current cycle.
    assign w_grant_ok = !rst && !bus.clr && (r_state == ST_IDLE);
    assign w_fire     = w_grant_ok && w_found;
    assign w_ready    = w_fire ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (bus.clr) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire && (MIN_GAP > 0)) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    // The last gap cycle is the one that sees a count of 1.
                    if (r_cnt <= c_CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_data   <= RESET_VALUE;
            r_owner  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (bus.clr) begin
                // Pointer deliberately kept so fairness survives a clear.
                r_data   <= RESET_VALUE;
                r_owner  <= '0;
                r_strobe <= 1'b0;
            end else if (w_fire) begin
                r_data   <= w_req_word[w_win];
                r_owner  <= w_win;
                r_strobe <= 1'b1;
                r_ptr    <= (w_win == c_LAST_ID) ? '0 : w_win + c_ID_W'(1);
            end else begin
                r_strobe <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.data_out  = r_data;
    assign bus.owner_id  = r_owner;
    assign bus.wr_strobe = r_strobe;
    assign bus.busy      = (r_state == ST_GAP);

endmodule
`default_nettype wire

// File: tb/tb_register_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_arbiter
// Description : Self-checking bench for register_arbiter. One instance with
//               MIN_GAP=2 and one with MIN_GAP=0 share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_arbiter_if #(.DATA_WIDTH(16), .NUM_REQ(4)) bus_a ();
    register_arbiter_if #(.DATA_WIDTH(16), .NUM_REQ(4)) bus_b ();

    register_arbiter #(
        .DATA_WIDTH(16), .NUM_REQ(4), .MIN_GAP(2), .RESET_VALUE(16'h0000)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    register_arbiter #(
        .DATA_WIDTH(16), .NUM_REQ(4), .MIN_GAP(0), .RESET_VALUE(16'h0000)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        clr;
        logic [3:0]  exp_ready;
        logic        exp_strobe;
        logic [1:0]  exp_owner;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [10];

    // Reference model state for the randomized phase
    int          m_ptr;
    int          m_gap;
    logic [15:0] m_data;
    int          m_owner;
    logic        m_strobe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [15:0] d0, d1, d2, d3);
        bus_a.req_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.clr = 1'b0;
        bus_a.req_valid = 4'b0000;
        bus_b.clr = 1'b0;
        bus_b.req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // Winner predicted by scanning upward from the pointer, or -1.
    function automatic int model_winner(input logic [3:0] v, input logic c);
        if (c || m_gap > 0) return -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          strobe_owner [$];
        int          strobe_cycle [$];
        logic [15:0] rd [4];
        int          w;
        logic        rc;
        logic [3:0]  rv;

        // ---------------- reset state (RST held high) ----------------
        rst = 1'b1;
        bus_a.clr = 1'b0;
        bus_b.clr = 1'b0;
        bus_a.req_valid = 4'b1111;
        bus_b.req_valid = 4'b0000;
        set_data(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus_b.req_data = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", bus_a.req_ready, 4'b0000);
        chk("reset_data", bus_a.data_out, 16'h0000);
        chk("reset_owner", bus_a.owner_id, 0);
        chk("reset_strobe", bus_a.wr_strobe, 0);
        chk("reset_busy", bus_a.busy, 0);
        do_reset();

        // ---------------- table-driven grant sequence ----------------
        tbl[0] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h3333};
        tbl[1] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[2] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[3] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[4] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[6] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[7] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[8] = '{4'b1110, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h2222};
        tbl[9] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111};
        for (int i = 0; i < 10; i++) begin
            bus_a.req_valid = tbl[i].valid;
            bus_a.clr = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d_ready", i), bus_a.req_ready, tbl[i].exp_ready);
            post_edge();
            bus_a.req_valid = 4'b0000;
            bus_a.clr = 1'b0;
            chk($sformatf("tbl%0d_strobe", i), bus_a.wr_strobe, tbl[i].exp_strobe);
            chk($sformatf("tbl%0d_owner", i), bus_a.owner_id, tbl[i].exp_owner);
            chk($sformatf("tbl%0d_data", i), bus_a.data_out, tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy", i), bus_a.busy, tbl[i].exp_strobe);
            if (tbl[i].exp_strobe) begin
                repeat (2) post_edge();
                chk($sformatf("tbl%0d_gap_end", i), bus_a.busy, 0);
            end
        end

        // ---------------- single requester 0xBEEF ----------------
        do_reset();
        set_data(16'h1111, 16'h2222, 16'hBEEF, 16'h4444);
        bus_a.req_valid = 4'b0100;
        #1;
        chk("single_ready", bus_a.req_ready, 4'b0100);
        post_edge();
        bus_a.req_valid = 4'b0000;
        chk("single_data", bus_a.data_out, 16'hBEEF);
        chk("single_owner", bus_a.owner_id, 2);
        chk("single_strobe", bus_a.wr_strobe, 1);
        chk("single_busy1", bus_a.busy, 1);
        #1;
        chk("single_gap_ready", bus_a.req_ready, 4'b0000);
        post_edge();
        chk("single_busy2", bus_a.busy, 1);
        chk("single_strobe_low", bus_a.wr_strobe, 0);
        post_edge();
        chk("single_busy3", bus_a.busy, 0);

        // ---------------- full contention ----------------
        do_reset();
        set_data(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        bus_a.req_valid = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            post_edge();
            if (bus_a.wr_strobe) begin
                strobe_owner.push_back(int'(bus_a.owner_id));
                strobe_cycle.push_back(c);
                chk($sformatf("contend_data%0d", c), bus_a.data_out,
                    16'h1111 * (int'(bus_a.owner_id) + 1));
            end
        end
        bus_a.req_valid = 4'b0000;
        chk("contend_count", strobe_owner.size(), 5);
        for (int k = 0; k < strobe_owner.size() && k < 5; k++) begin
            chk($sformatf("contend_owner%0d", k), strobe_owner[k], k % 4);
            if (k > 0)
                chk($sformatf("contend_space%0d", k), strobe_cycle[k] - strobe_cycle[k-1], 3);
        end

        // ---------------- clear during GAP ----------------
        do_reset();
        bus_a.req_valid = 4'b0001;
        post_edge();
        chk("clrgap_commit", bus_a.data_out, 16'h1111);
        bus_a.req_valid = 4'b0010;
        bus_a.clr = 1'b1;
        #1;
        chk("clrgap_ready_held", bus_a.req_ready, 4'b0000);
        post_edge();
        bus_a.clr = 1'b0;
        chk("clrgap_busy", bus_a.busy, 0);
        chk("clrgap_strobe", bus_a.wr_strobe, 0);
        chk("clrgap_data", bus_a.data_out, 16'h0000);
        #1;
        chk("clrgap_ready", bus_a.req_ready, 4'b0010);
        post_edge();
        bus_a.req_valid = 4'b0000;
        chk("clrgap_owner", bus_a.owner_id, 1);
        chk("clrgap_data2", bus_a.data_out, 16'h2222);
        chk("clrgap_strobe2", bus_a.wr_strobe, 1);

        // ---------------- reset mid-gap ----------------
        do_reset();
        bus_a.req_valid = 4'b0001;
        post_edge();
        bus_a.req_valid = 4'b0100;
        post_edge();
        chk("rstgap_pre_busy", bus_a.busy, 1);
        chk("rstgap_pre_data", bus_a.data_out, 16'h1111);
        #1 rst = 1'b1;
        #1;
        chk("rstgap_data", bus_a.data_out, 16'h0000);
        chk("rstgap_owner", bus_a.owner_id, 0);
        chk("rstgap_busy", bus_a.busy, 0);
        chk("rstgap_ready", bus_a.req_ready, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstgap_regrant", bus_a.req_ready, 4'b0100);
        post_edge();
        bus_a.req_valid = 4'b0000;
        chk("rstgap_owner2", bus_a.owner_id, 2);
        chk("rstgap_data2", bus_a.data_out, 16'h3333);

        // ---------------- MIN_GAP=0 instance ----------------
        do_reset();
        bus_b.req_valid = 4'b0011;
        #1;
        chk("gap0_ready0", bus_b.req_ready, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            post_edge();
            chk($sformatf("gap0_owner%0d", k), bus_b.owner_id, k % 2);
            chk($sformatf("gap0_strobe%0d", k), bus_b.wr_strobe, 1);
            chk($sformatf("gap0_busy%0d", k), bus_b.busy, 0);
            chk($sformatf("gap0_data%0d", k), bus_b.data_out, (k % 2) ? 16'h0B0B : 16'h0A0A);
        end
        bus_b.req_valid = 4'b0000;

        // ---------------- randomized vs reference model ----------------
        do_reset();
        m_ptr = 0;
        m_gap = 0;
        m_data = 16'h0000;
        m_owner = 0;
        m_strobe = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rv = 4'($urandom);
            rc = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < 4; j++) rd[j] = 16'($urandom);
            bus_a.req_valid = rv;
            bus_a.clr = rc;
            set_data(rd[0], rd[1], rd[2], rd[3]);
            w = model_winner(rv, rc);
            #1;
            chk($sformatf("rnd%0d_ready", n), bus_a.req_ready,
                (w >= 0) ? (4'b0001 << w) : 4'b0000);
            post_edge();
            if (rc) begin
                m_data = 16'h0000;
                m_owner = 0;
                m_strobe = 1'b0;
                m_gap = 0;
            end else if (w >= 0) begin
                m_data = rd[w];
                m_owner = w;
                m_strobe = 1'b1;
                m_ptr = (w + 1) % 4;
                m_gap = 2;
            end else begin
                m_strobe = 1'b0;
                if (m_gap > 0) m_gap = m_gap - 1;
            end
            chk($sformatf("rnd%0d_data", n), bus_a.data_out, m_data);
            chk($sformatf("rnd%0d_owner", n), bus_a.owner_id, m_owner);
            chk($sformatf("rnd%0d_strobe", n), bus_a.wr_strobe, m_strobe);
            chk($sformatf("rnd%0d_busy", n), bus_a.busy, m_gap > 0);
        end
        bus_a.req_valid = 4'b0000;
        bus_a.clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
